// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: decides whether D may advance (register and HI/LO hazards)
// and sequences the shared multiply/divide unit's busy window.
module md_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic        E_regWrite,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_A3,
    input  logic        M_regWrite,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_op,
    output logic        stall,
    output logic        F_en,
    output logic        D_en,
    output logic        E_clr,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx, load_cnt;
    logic rs_haz, rt_haz, md_haz;
    assign rs_haz = (E_regWrite && E_A3 != 5'd0 && E_A3 == D_A1 && D_tuse_rs < E_tnew) ||
                    (M_regWrite && M_A3 != 5'd0 && M_A3 == D_A1 && D_tuse_rs < M_tnew);
    assign rt_haz = (E_regWrite && E_A3 != 5'd0 && E_A3 == D_A2 && D_tuse_rt < E_tnew) ||
                    (M_regWrite && M_A3 != 5'd0 && M_A3 == D_A2 && D_tuse_rt < M_tnew);
    // a start in E already claims the unit, so a HI/LO user in D must wait too
    assign md_haz   = D_is_md && (state == BUSY || E_md_start);
    assign stall    = reset && (rs_haz || rt_haz || md_haz);
    assign F_en     = ~stall;
    assign D_en     = ~stall;
    assign E_clr    = stall;
    assign md_busy  = state == BUSY;
    assign md_done  = state == DONE;
    assign load_cnt = E_md_op ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    // IDLE and DONE behave alike: a start loads the counter, otherwise fall to IDLE
    always_comb begin
        state_nx = IDLE;
        cnt_nx   = cnt;
        if (state == BUSY) begin
            cnt_nx   = cnt - 4'd1;
            state_nx = cnt == 4'd1 ? DONE : BUSY;
        end else if (E_md_start) begin
            cnt_nx   = load_cnt;
            state_nx = BUSY;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb_md_hazard_ctrl: directed stimulus against a cycle-level model of the
// hazard rules and the multiply/divide busy window.
module tb_md_hazard_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_A1, D_A2, E_A3, M_A3;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_regWrite, M_regWrite, E_md_start, E_md_op;
    logic        stall, F_en, D_en, E_clr, md_busy, md_done;
    logic [31:0] stall_cnt;
    int          vectors = 0;
    int          miscompares = 0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_cnt = '0;
    logic        preload = 1'b0;
    logic        m_stall;

    always #5 clk = ~clk;

    md_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .D_A1(D_A1), .D_A2(D_A2),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_is_md(D_is_md),
        .E_A3(E_A3), .E_regWrite(E_regWrite), .E_tnew(E_tnew),
        .M_A3(M_A3), .M_regWrite(M_regWrite), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_op(E_md_op),
        .stall(stall), .F_en(F_en), .D_en(D_en), .E_clr(E_clr),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    function automatic logic dep(input logic [4:0] src, input logic [1:0] tuse,
                                 input logic [4:0] dst, input logic wr, input logic [1:0] tnew);
        return wr && dst != 5'd0 && dst == src && tuse < tnew;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    always_comb
        m_stall = reset && ((D_is_md && (m_left > 0 || E_md_start)) ||
                  dep(D_A1, D_tuse_rs, E_A3, E_regWrite, E_tnew) ||
                  dep(D_A1, D_tuse_rs, M_A3, M_regWrite, M_tnew) ||
                  dep(D_A2, D_tuse_rt, E_A3, E_regWrite, E_tnew) ||
                  dep(D_A2, D_tuse_rt, M_A3, M_regWrite, M_tnew));

    // m_left counts remaining busy cycles; done follows the last one
    always @(posedge clk) begin
        if (!reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_cnt  <= '0;
        end else begin
            m_cnt <= sat_inc(preload ? 32'hFFFF_FFFD : m_cnt, m_stall);
            if (m_left > 0) begin
                m_left <= m_left - 1;
                m_done <= m_left == 1;
            end else begin
                m_done <= 1'b0;
                if (E_md_start) m_left <= E_md_op ? DIV_N : MULT_N;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", {31'd0, stall}, {31'd0, m_stall});
        chk("F_en", {31'd0, F_en}, {31'd0, !m_stall});
        chk("D_en", {31'd0, D_en}, {31'd0, !m_stall});
        chk("E_clr", {31'd0, E_clr}, {31'd0, m_stall});
        chk("md_busy", {31'd0, md_busy}, {31'd0, m_left > 0});
        chk("md_done", {31'd0, md_done}, {31'd0, m_done});
        chk("stall_cnt", stall_cnt, m_cnt);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_regs();
        E_regWrite = 0; M_regWrite = 0; E_A3 = 0; M_A3 = 0; D_A1 = 0; D_A2 = 0;
        D_tuse_rs = 3; D_tuse_rt = 3; E_tnew = 0; M_tnew = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        tick();
        reset = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_regs();
        reset = 0; D_is_md = 1; E_md_start = 1; E_md_op = 0;
        tick();
        tick();
        chk("lit_reset_busy", {31'd0, md_busy}, 32'd0);
        chk("lit_reset_done", {31'd0, md_done}, 32'd0);
        chk("lit_reset_cnt", stall_cnt, 32'd0);
        chk("lit_reset_fen", {31'd0, F_en}, 32'd1);
        chk("lit_reset_stall", {31'd0, stall}, 32'd0);
        reset = 1; D_is_md = 0; E_md_start = 0;
        tick();
        // load-use against E, then the same with $0 as destination
        E_A3 = 5; E_regWrite = 1; E_tnew = 2; D_A1 = 5; D_tuse_rs = 1;
        tick();
        chk("lit_loaduse_stall", {31'd0, stall}, 32'd1);
        chk("lit_loaduse_eclr", {31'd0, E_clr}, 32'd1);
        chk("lit_loaduse_cnt", stall_cnt, 32'd1);
        E_A3 = 0; D_A1 = 0;
        tick();
        chk("lit_r0_stall", {31'd0, stall}, 32'd0);
        clr_regs();
        M_A3 = 7; M_regWrite = 1; M_tnew = 1; D_A2 = 7; D_tuse_rt = 0;
        tick();
        chk("lit_m_rt_stall", {31'd0, stall}, 32'd1);
        D_tuse_rt = 1;
        tick();
        chk("lit_tuse_eq_tnew", {31'd0, stall}, 32'd0);
        M_regWrite = 0; D_tuse_rt = 0;
        tick();
        clr_regs();
        do_reset();
        // mult with mfhi waiting in D, plus an overlapping register hazard
        D_is_md = 1; E_md_start = 1; E_md_op = 0;
        E_A3 = 5; E_regWrite = 1; E_tnew = 2; D_A1 = 5; D_tuse_rs = 0;
        tick();
        E_md_start = 0;
        clr_regs();
        for (int i = 0; i < MULT_N; i++) begin
            chk("lit_mult_busy", {31'd0, md_busy}, 32'd1);
            chk("lit_mult_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        chk("lit_mult_done", {31'd0, md_done}, 32'd1);
        chk("lit_mult_free", {31'd0, stall}, 32'd0);
        chk("lit_mult_cnt", stall_cnt, 32'd6);
        D_is_md = 0;
        tick();
        do_reset();
        // div aborted by reset in its fourth busy cycle
        E_md_start = 1; E_md_op = 1;
        tick();
        E_md_start = 0;
        tick(); tick(); tick();
        chk("lit_div_busy4", {31'd0, md_busy}, 32'd1);
        reset = 0;
        tick();
        chk("lit_abort_busy", {31'd0, md_busy}, 32'd0);
        chk("lit_abort_cnt", stall_cnt, 32'd0);
        reset = 1;
        for (int i = 0; i < DIV_N + 2; i++) begin
            chk("lit_abort_nodone", {31'd0, md_done}, 32'd0);
            tick();
        end
        // back-to-back: div starts in the mult's DONE cycle
        E_md_start = 1; E_md_op = 0;
        tick();
        E_md_start = 0;
        for (int i = 0; i < MULT_N; i++) tick();
        chk("lit_b2b_done", {31'd0, md_done}, 32'd1);
        E_md_start = 1; E_md_op = 1;
        tick();
        E_md_start = 0;
        for (int i = 0; i < DIV_N; i++) begin
            chk("lit_b2b_busy", {31'd0, md_busy}, 32'd1);
            tick();
        end
        chk("lit_b2b_done2", {31'd0, md_done}, 32'd1);
        chk("lit_b2b_idle", {31'd0, md_busy}, 32'd0);
        tick();
        // saturation via back-door preload of the counter
        do_reset();
        E_A3 = 9; E_regWrite = 1; E_tnew = 2; D_A2 = 9; D_tuse_rt = 0;
        preload = 1;
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        tick();
        preload = 0;
        chk("lit_sat_fe", stall_cnt, 32'hFFFF_FFFE);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("lit_sat_max", stall_cnt, 32'hFFFF_FFFF);
            tick();
        end
        clr_regs();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/md_hazard_ctrl.md
# md_hazard_ctrl

Pipeline hazard and multiply/divide scheduler for the five-stage core. It decides each cycle whether the instruction in D may advance, using register-dependency checks against E and M and the occupancy of the shared HI/LO multiply/divide unit. It drives the F/D enables and the D→E bubble insert, and sequences the multiply/divide unit's busy window.

## Interface
Parameters:
- MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- D_A1  in  5  rs address of the instruction in D.
- D_A2  in  5  rt address of the instruction in D.
- D_tuse_rs  in  2  cycles until D needs rs (0..2; 3 = not used).
- D_tuse_rt  in  2  cycles until D needs rt (0..2; 3 = not used).
- D_is_md  in  1  D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- E_A3  in  5  destination register of the instruction in E.
- E_regWrite  in  1  E instruction writes the register file.
- E_tnew  in  2  cycles until E's result is forwardable.
- M_A3  in  5  destination register of the instruction in M.
- M_regWrite  in  1  M instruction writes the register file.
- M_tnew  in  2  cycles until M's result is forwardable.
- E_md_start  in  1  E holds a mult/div this cycle.
- E_md_op  in  1  0 = mult class, 1 = div class.
- stall  out  1  D must hold (combinational).
- F_en  out  1  PC/F→D register enable = ~stall.
- D_en  out  1  D→E advance enable = ~stall.
- E_clr  out  1  insert bubble into D→E register = stall.
- md_busy  out  1  multiply/divide unit occupied (registered).
- md_done  out  1  one-cycle pulse: HI/LO result valid (registered).
- stall_cnt  out  32  total stall cycles since reset, saturating at 0xFFFFFFFF.

## Operation
- Register hazard, rs: E_regWrite && E_A3!=0 && E_A3==D_A1 && D_tuse_rs < E_tnew; same check against M using M_regWrite/M_A3/M_tnew. The rt check is identical, using D_A2/D_tuse_rt. Register $0 never causes a hazard.
- MD hazard: D_is_md && (md_busy || E_md_start).
- stall = rs hazard | rt hazard | MD hazard. Forced to 0 while reset==0.
- MD FSM states: IDLE, BUSY, DONE.
  - IDLE: on E_md_start, load cnt = (E_md_op ? DIV_CYCLES : MULT_CYCLES) and go to BUSY.
  - BUSY: cnt decrements each edge. When cnt==1 at an edge, go to DONE.
  - DONE: lasts one cycle, then IDLE. If E_md_start arrives in DONE, load and go to BUSY directly.
- E_md_start while in BUSY is ignored (the stall logic guarantees it cannot occur).
- md_busy = (state==BUSY). md_done = (state==DONE).
- stall_cnt increments on every edge where stall==1, and holds at the maximum value.
- Reset (reset==0 at an edge): state IDLE, cnt 0, md_busy 0, md_done 0, stall_cnt 0.
  - A reset mid-BUSY aborts the operation and produces no md_done.
  - Outputs during reset: stall 0, F_en 1, D_en 1, E_clr 0.

## Timing
- stall, F_en, D_en, E_clr are combinational from the current inputs and state, with zero latency.
- A start sampled at edge t gives md_busy=1 for exactly N cycles (t+1 .. t+N), then md_done=1 for cycle t+N+1.
- A D-stage mfhi behind a mult is stalled during the start cycle and all N busy cycles. It advances in the md_done cycle, for N+1 stall cycles total.
- Simultaneous register hazard and MD hazard count as one stall cycle.
- Back-to-back operation: a start in the DONE cycle re-enters BUSY with no IDLE gap, and md_done still pulses in that cycle.

## Test plan
- Reset: hold reset=0 for 2 cycles with E_md_start=1 -> md_busy=0, md_done=0, stall_cnt=0, F_en=1.
- Load-use: E_A3=5, E_regWrite=1, E_tnew=2; D_A1=5, D_tuse_rs=1 -> stall=1, E_clr=1. Repeat with E_A3=0 -> stall=0.
- mult then mfhi (MULT_CYCLES=5): start at edge t with D_is_md=1 held -> md_busy high t+1..t+5, md_done at t+6, stall high for 6 cycles, stall_cnt=6.
- div (DIV_CYCLES=10) with reset=0 asserted at busy cycle 4 -> md_busy drops next edge, no md_done pulse, stall_cnt=0.
- Back-to-back: mult start, then div start in the DONE cycle -> md_done=1 and md_busy=1 on the following edge for 10 cycles.
- Saturation: force stall for 2^32+3 cycles (or preload via bench back-door) -> stall_cnt stays 0xFFFFFFFF.
